bal_mac_sched: RTL and testbench

BAL_MAC_SCHED -- requirements
Module: bal_mac_sched

---
 rtl/bal_pkg.sv | 33 +++
 rtl/bal_mac_sched_if.sv | 28 ++
 rtl/bal_mult.sv | 14 +
 rtl/bal_mac_sched.sv | 170 +++++++++++++++++
 tb/tb_bal_mac_sched.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/bal_pkg.sv
// Shared types and constants for the balance MAC scheduler.
package bal_pkg;

  localparam int PTCH_W  = 10;
  localparam int SS_W    = 8;
  localparam int STEER_W = 12;
  localparam int PID_W   = 12;
  localparam int P_W     = 15;

  // Shared multiplier geometry: signed 13 x signed 10 -> 23.
  localparam int A_W    = 13;
  localparam int B_W    = 10;
  localparam int PROD_W = A_W + B_W;

  localparam int P_COEFF     = 9;
  localparam int STEER_NUM   = 3;
  localparam int SS_SHIFT    = 8;
  localparam int STEER_SHIFT = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_P   = 3'd1,
    MUL_SS  = 3'd2,
    MUL_STR = 3'd3,
    DONE    = 3'd4
  } bal_state_t;

  // Small positive constant presented on the multiplier B port.
  function automatic logic signed [B_W-1:0] coeff_b(input int k);
    return B_W'(k);
  endfunction

endpackage

// File: rtl/bal_mac_sched_if.sv
// Sample/result bundle between the balance controller and the MAC scheduler.
interface bal_mac_sched_if;
  import bal_pkg::*;

  logic                      vld;
  logic signed [PTCH_W-1:0]  ptch_err_sat;
  logic        [SS_W-1:0]    ss_tmr;
  logic signed [STEER_W-1:0] steer_sat;
  logic signed [PID_W-1:0]   PID_cntrl;

  logic signed [P_W-1:0]     P_term;
  logic signed [PID_W-1:0]   PID_ss;
  logic signed [STEER_W-1:0] steer_scaled;
  logic                      done;
  logic                      busy;
  logic                      overrun;

  modport master (
    output vld, ptch_err_sat, ss_tmr, steer_sat, PID_cntrl,
    input  P_term, PID_ss, steer_scaled, done, busy, overrun
  );

  modport slave (
    input  vld, ptch_err_sat, ss_tmr, steer_sat, PID_cntrl,
    output P_term, PID_ss, steer_scaled, done, busy, overrun
  );

endinterface

// File: rtl/bal_mult.sv
// The one shared signed multiplier; purely combinational.
module bal_mult
  import bal_pkg::*;
(
  input  logic signed [A_W-1:0]    a,
  input  logic signed [B_W-1:0]    b,
  output logic signed [PROD_W-1:0] p
);

  // Both operands widened to the product width before multiplying so the
  // full 23-bit signed result is kept.
  assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/bal_mac_sched.sv
// Time-multiplexed MAC scheduler: one multiplier serves the pitch P term,
// the soft-start PID scaling and the steering scaling in turn.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for vld or a pending request
// MUL_P   | multiplier computes ptch_err_sat * 9
// MUL_SS  | multiplier computes PID_cntrl * ss_tmr; P_term updates
// MUL_STR | multiplier computes steer_sat * 3; PID_ss updates
// DONE    | steer_scaled updates; done pulses in the following cycle
module bal_mac_sched
  import bal_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  bal_mac_sched_if.slave bus
);

  bal_state_t state, state_nxt;
  logic       busy_c;
  logic       start;

  logic signed [PTCH_W-1:0]  ptch_op,  ptch_sh;
  logic        [SS_W-1:0]    ss_op,    ss_sh;
  logic signed [STEER_W-1:0] steer_op, steer_sh;
  logic                      pend;
  logic                      overrun_r;

  logic signed [A_W-1:0]     mul_a;
  logic signed [B_W-1:0]     mul_b;
  logic signed [PROD_W-1:0]  mul_p;
  logic signed [PROD_W-1:0]  prod_r;

  logic signed [P_W-1:0]     p_term_r;
  logic signed [PID_W-1:0]   pid_ss_r;
  logic signed [STEER_W-1:0] steer_r;
  logic                      done_r;

  // Product bits above bit 19 are never needed: the operand ranges keep
  // every result inside the slices taken below.
  logic unused_prod_hi;
  assign unused_prod_hi = ^prod_r[PROD_W-1:SS_SHIFT+PID_W];

  assign start = (state == IDLE) && (bus.vld || pend);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and busy decode.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b1;
    unique case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.vld || pend) state_nxt = MUL_P;
      end
      MUL_P:   state_nxt = MUL_SS;
      MUL_SS:  state_nxt = MUL_STR;
      MUL_STR: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, one-deep pending shadow and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_op   <= '0;
      ss_op     <= '0;
      steer_op  <= '0;
      ptch_sh   <= '0;
      ss_sh     <= '0;
      steer_sh  <= '0;
      pend      <= 1'b0;
      overrun_r <= 1'b0;
    end else if (start) begin
      if (pend) begin
        // Shadow is consumed; a vld on this same edge refills it.
        ptch_op  <= ptch_sh;
        ss_op    <= ss_sh;
        steer_op <= steer_sh;
        pend     <= bus.vld;
        if (bus.vld) begin
          ptch_sh  <= bus.ptch_err_sat;
          ss_sh    <= bus.ss_tmr;
          steer_sh <= bus.steer_sat;
        end
      end else begin
        ptch_op  <= bus.ptch_err_sat;
        ss_op    <= bus.ss_tmr;
        steer_op <= bus.steer_sat;
      end
    end else if (bus.vld) begin
      // Not starting while vld is high means a pass is in flight.
      if (pend) begin
        overrun_r <= 1'b1;
      end else begin
        pend     <= 1'b1;
        ptch_sh  <= bus.ptch_err_sat;
        ss_sh    <= bus.ss_tmr;
        steer_sh <= bus.steer_sat;
      end
    end
  end

  // Operand muxes in front of the shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state)
      MUL_P: begin
        mul_a = {{(A_W-PTCH_W){ptch_op[PTCH_W-1]}}, ptch_op};
        mul_b = coeff_b(P_COEFF);
      end
      MUL_SS: begin
        mul_a = {{(A_W-PID_W){bus.PID_cntrl[PID_W-1]}}, bus.PID_cntrl};
        mul_b = {{(B_W-SS_W){1'b0}}, ss_op};
      end
      MUL_STR: begin
        mul_a = {{(A_W-STEER_W){steer_op[STEER_W-1]}}, steer_op};
        mul_b = coeff_b(STEER_NUM);
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  bal_mult u_mult (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // Product register and staggered result loads; each result lands one
  // state after its multiply so the multiplier path ends at a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r   <= '0;
      p_term_r <= '0;
      pid_ss_r <= '0;
      steer_r  <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= (state == DONE);
      if (state == MUL_P || state == MUL_SS || state == MUL_STR)
        prod_r <= mul_p;
      unique case (state)
        MUL_SS:  p_term_r <= prod_r[P_W-1:0];
        MUL_STR: pid_ss_r <= prod_r[SS_SHIFT+PID_W-1:SS_SHIFT];
        // Taking bits [15:4] is the arithmetic floor shift by 4.
        DONE:    steer_r  <= prod_r[STEER_SHIFT+STEER_W-1:STEER_SHIFT];
        default: ;
      endcase
    end
  end

  assign bus.P_term       = p_term_r;
  assign bus.PID_ss       = pid_ss_r;
  assign bus.steer_scaled = steer_r;
  assign bus.done         = done_r;
  assign bus.busy         = busy_c;
  assign bus.overrun      = overrun_r;

endmodule

// File: tb/tb_bal_mac_sched.sv
// Self-checking bench for bal_mac_sched against a pass-level timing model.
module tb_bal_mac_sched;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  bal_mac_sched_if bus ();

  bal_mac_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: when each accepted request started and its operands.
  int act_s, act_ptch, act_ss, act_steer;
  bit pend;
  int pend_ptch, pend_ss, pend_steer;
  int m_p, m_ss, m_st;
  bit m_ov;
  int pid_cur;

  bit use_dir;
  int d_ptch, d_ss, d_steer;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    act_s = -100;
    pend  = 1'b0;
    m_p   = 0;
    m_ss  = 0;
    m_st  = 0;
    m_ov  = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_p_term"},  bus.P_term,       0);
    chk({tag, "_pid_ss"},  bus.PID_ss,       0);
    chk({tag, "_steer"},   bus.steer_scaled, 0);
    chk({tag, "_done"},    bus.done,         0);
    chk({tag, "_busy"},    bus.busy,         0);
    chk({tag, "_overrun"}, bus.overrun,      0);
  endtask

  function automatic int rand_s12();
    logic signed [11:0] r;
    r = 12'($urandom);
    return r;
  endfunction

  // Drives a vld pattern (bit c of vmask = vld before edge c) and checks
  // every output after every edge against the model.
  task automatic run_seq(input int ncyc, input bit [31:0] vmask, input int pid);
    logic signed [9:0]  r10;
    logic        [7:0]  r8;
    logic signed [11:0] r12;
    int in_p, in_ss, in_st;
    bit v, idle, exp_done, exp_busy;
    bit first = 1'b1;
    pid_cur       = pid;
    bus.PID_cntrl = 12'(pid);
    for (int c = 0; c < ncyc; c++) begin
      v     = (c < 32) ? vmask[c] : 1'b0;
      r10   = 10'($urandom);
      r8    = 8'($urandom);
      r12   = 12'($urandom);
      in_p  = r10;
      in_ss = r8;
      in_st = r12;
      if (v && first && use_dir) begin
        in_p  = d_ptch;
        in_ss = d_ss;
        in_st = d_steer;
      end
      if (v) first = 1'b0;
      bus.vld          = v;
      bus.ptch_err_sat = 10'(in_p);
      bus.ss_tmr       = 8'(in_ss);
      bus.steer_sat    = 12'(in_st);
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == act_s + 2) m_p  = act_ptch * 9;
      if (cyc == act_s + 3) m_ss = (pid_cur * act_ss) >>> 8;
      if (cyc == act_s + 4) m_st = (act_steer * 3) >>> 4;
      exp_done = (cyc == act_s + 4);
      idle     = !(cyc >= act_s + 1 && cyc <= act_s + 4);
      if (idle) begin
        if (pend) begin
          act_s = cyc; act_ptch = pend_ptch; act_ss = pend_ss; act_steer = pend_steer;
          pend = v;
          if (v) begin pend_ptch = in_p; pend_ss = in_ss; pend_steer = in_st; end
        end else if (v) begin
          act_s = cyc; act_ptch = in_p; act_ss = in_ss; act_steer = in_st;
        end
      end else if (v) begin
        if (pend) m_ov = 1'b1;
        else begin
          pend = 1'b1; pend_ptch = in_p; pend_ss = in_ss; pend_steer = in_st;
        end
      end
      exp_busy = (cyc >= act_s && cyc < act_s + 4);
      chk("p_term",       bus.P_term,       m_p);
      chk("pid_ss",       bus.PID_ss,       m_ss);
      chk("steer_scaled", bus.steer_scaled, m_st);
      chk("done",         bus.done,         exp_done);
      chk("busy",         bus.busy,         exp_busy);
      chk("overrun",      bus.overrun,      m_ov);
    end
    bus.vld = 1'b0;
    use_dir = 1'b0;
  endtask

  task automatic do_reset();
    bus.vld = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk_zero("reset_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    bus.vld          = 1'b0;
    bus.ptch_err_sat = '0;
    bus.ss_tmr       = '0;
    bus.steer_sat    = '0;
    bus.PID_cntrl    = '0;
    use_dir          = 1'b0;
    model_clear();

    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // Single pass with positive extremes.
    use_dir = 1'b1; d_ptch = 511; d_ss = 255; d_steer = -1535;
    run_seq(8, 32'h1, 2047);
    chk("dir34_p_term", bus.P_term,       32'sh11F7);
    chk("dir34_pid_ss", bus.PID_ss,       32'sh7F7);
    chk("dir34_steer",  bus.steer_scaled, -288);

    // Negative extremes.
    use_dir = 1'b1; d_ptch = -512; d_ss = 128; d_steer = 1536;
    run_seq(8, 32'h1, -2048);
    chk("dir35_p_term", bus.P_term,       -4608);
    chk("dir35_pid_ss", bus.PID_ss,       -1024);
    chk("dir35_steer",  bus.steer_scaled, 288);

    // Zero soft-start scale, then zero PID.
    use_dir = 1'b1; d_ptch = -77; d_ss = 0; d_steer = 700;
    run_seq(8, 32'h1, 1234);
    chk("ss_zero_pid_ss", bus.PID_ss, 0);
    use_dir = 1'b1; d_ptch = 300; d_ss = 200; d_steer = -9;
    run_seq(8, 32'h1, 0);
    chk("pid_zero_pid_ss", bus.PID_ss, 0);

    // Back-to-back, refill on the consume edge, then overrun.
    run_seq(14, 32'b101, rand_s12());
    run_seq(20, 32'b100011, rand_s12());
    chk("no_overrun_yet", bus.overrun, 0);
    run_seq(14, 32'b111, rand_s12());
    chk("overrun_set", bus.overrun, 1);

    // Random traffic; overrun must stay set throughout.
    repeat (3) run_seq(42, $urandom | $urandom, rand_s12());

    do_reset();
    repeat (3) run_seq(42, $urandom & $urandom, rand_s12());
    repeat (2) run_seq(42, $urandom, rand_s12());

    // Reset while the steering multiply is in progress.
    do_reset();
    run_seq(3, 32'h1, 555);
    #4 rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    run_seq(10, 32'h0, 555);
    run_seq(8, 32'h1, rand_s12());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
